// File: rtl/gray_seq_arb_if.sv
// -----------------------------------------------------------------------------
// gray_seq_arb_if
// Bundles the request/length/direction inputs and the grant/status outputs of
// the two-requester Gray-code sequencer arbiter.
//   master : requester side (drives req, len0/1, dir0/1, hold; sees status)
//   slave  : arbiter side   (sees requests; drives gnt, busy, done, done_id,
//            wrap, gray_count)
// -----------------------------------------------------------------------------
interface gray_seq_arb_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic             dir0;
    logic             dir1;
    logic             hold;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             wrap;
    logic [WIDTH-1:0] gray_count;

    modport master (
        output req, len0, len1, dir0, dir1, hold,
        input  gnt, busy, done, done_id, wrap, gray_count
    );

    modport slave (
        input  req, len0, len1, dir0, dir1, hold,
        output gnt, busy, done, done_id, wrap, gray_count
    );
endinterface

// File: rtl/gray_seq_arb.sv
// -----------------------------------------------------------------------------
// gray_seq_arb
// Two-requester round-robin arbiter that, for the granted requester, steps a
// shared binary counter up or down a requested number of times and presents it
// in Gray code.  The counter is not cleared between runs.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : gray_seq_arb_if.slave
//            req[1:0], len0/len1, dir0/dir1 (0=up, 1=down), hold  -> in
//            gnt[1:0] (one-hot), busy, done (pulse), done_id, wrap (pulse),
//            gray_count                                              -> out
// -----------------------------------------------------------------------------
module gray_seq_arb #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    gray_seq_arb_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] rem;
    logic             dir_r;
    logic             rr;
    logic             owner;
    logic             done_id_r;
    logic             wrap_r;

    logic             pick;
    logic [WIDTH-1:0] len_sel;
    logic             dir_sel;

    // Round-robin pointer only matters on a tie; a lone request wins outright.
    always_comb begin
        pick    = 1'b0;
        len_sel = bus.len0;
        dir_sel = bus.dir0;
        if (bus.req == 2'b11) begin
            pick = rr;
        end else begin
            pick = bus.req[1];
        end
        if (pick) begin
            len_sel = bus.len1;
            dir_sel = bus.dir1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bin       <= '0;
            rem       <= '0;
            dir_r     <= 1'b0;
            rr        <= 1'b0;
            owner     <= 1'b0;
            done_id_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        owner <= pick;
                        rem   <= len_sel;
                        dir_r <= dir_sel;
                        if (len_sel != '0) begin
                            state <= S_RUN;
                        end else begin
                            // Zero-length run: report completion without stepping.
                            state     <= S_DONE;
                            done_id_r <= pick;
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.hold) begin
                        bin    <= dir_r ? (bin - ONE) : (bin + ONE);
                        rem    <= rem - ONE;
                        wrap_r <= dir_r ? (bin == '0) : (&bin);
                        if (rem == ONE) begin
                            state     <= S_DONE;
                            done_id_r <= owner;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    rr    <= ~owner;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.done_id    = done_id_r;
    assign bus.wrap       = wrap_r;
    assign bus.gray_count = bin ^ (bin >> 1);

endmodule

// File: tb/tb_gray_seq_arb.sv
// -----------------------------------------------------------------------------
// tb_gray_seq_arb
// Directed testbench for gray_seq_arb (WIDTH = 4).  Inputs change and outputs
// are sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_gray_seq_arb;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    gray_seq_arb_if #(.WIDTH(4)) bus ();

    gray_seq_arb #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req  = 2'b00;
        bus.len0 = 4'd0;
        bus.len1 = 4'd0;
        bus.dir0 = 1'b0;
        bus.dir1 = 1'b0;
        bus.hold = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.gnt, bus.busy, bus.done, bus.done_id, bus.wrap, bus.gray_count} !== 10'd0) begin n_err++; $display("FAIL rst_init: got %b exp 0", {bus.gnt, bus.busy, bus.done, bus.done_id, bus.wrap, bus.gray_count}); end
        bus.req = 2'b01; bus.len0 = 4'd5; bus.dir0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL rst_pre_gnt: got %b exp 01", bus.gnt); end
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0001) begin n_err++; $display("FAIL rst_pre_gray: got %b exp 0001", bus.gray_count); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.gnt, bus.busy, bus.done, bus.done_id, bus.wrap, bus.gray_count} !== 10'd0) begin n_err++; $display("FAIL rst_async: got %b exp 0", {bus.gnt, bus.busy, bus.done, bus.done_id, bus.wrap, bus.gray_count}); end
        idle_inputs();
    endtask

    task automatic test_up_run();
        apply_reset();
        bus.req = 2'b01; bus.len0 = 4'd3; bus.dir0 = 1'b0;
        tick();
        n_cmp++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL up_gnt: got %b exp 01", bus.gnt); end
        n_cmp++; if (bus.gray_count !== 4'b0000) begin n_err++; $display("FAIL up_gray0: got %b exp 0000", bus.gray_count); end
        bus.req = 2'b00;
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0001) begin n_err++; $display("FAIL up_gray1: got %b exp 0001", bus.gray_count); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL up_busy: got %b exp 1", bus.busy); end
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0011) begin n_err++; $display("FAIL up_gray2: got %b exp 0011", bus.gray_count); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL up_early_done: got %b exp 0", bus.done); end
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0010) begin n_err++; $display("FAIL up_gray3: got %b exp 0010", bus.gray_count); end
        n_cmp++; if ({bus.done, bus.done_id, bus.gnt} !== 4'b1001) begin n_err++; $display("FAIL up_done: got %b exp 1001", {bus.done, bus.done_id, bus.gnt}); end
        tick();
        n_cmp++; if ({bus.done, bus.busy, bus.gnt} !== 4'b0000) begin n_err++; $display("FAIL up_idle: got %b exp 0000", {bus.done, bus.busy, bus.gnt}); end
    endtask

    task automatic test_arbitration();
        bus.req = 2'b11; bus.len0 = 4'd1; bus.len1 = 4'd1; bus.dir0 = 1'b0; bus.dir1 = 1'b0;
        apply_reset();
        tick();
        n_cmp++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL arb_first: got %b exp 01", bus.gnt); end
        tick();
        n_cmp++; if ({bus.done, bus.done_id, bus.gnt} !== 4'b1001) begin n_err++; $display("FAIL arb_done0: got %b exp 1001", {bus.done, bus.done_id, bus.gnt}); end
        tick();
        n_cmp++; if ({bus.busy, bus.gnt} !== 3'b000) begin n_err++; $display("FAIL arb_gap: got %b exp 000", {bus.busy, bus.gnt}); end
        tick();
        n_cmp++; if (bus.gnt !== 2'b10) begin n_err++; $display("FAIL arb_second: got %b exp 10", bus.gnt); end
        tick();
        n_cmp++; if ({bus.done, bus.done_id, bus.gnt} !== 4'b1110) begin n_err++; $display("FAIL arb_done1: got %b exp 1110", {bus.done, bus.done_id, bus.gnt}); end
        tick();
        n_cmp++; if ({bus.done, bus.done_id, bus.gnt} !== 4'b0100) begin n_err++; $display("FAIL arb_doneid_hold: got %b exp 0100", {bus.done, bus.done_id, bus.gnt}); end
        tick();
        n_cmp++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL arb_third: got %b exp 01", bus.gnt); end
        bus.req = 2'b00;
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0010) begin n_err++; $display("FAIL arb_gray: got %b exp 0010", bus.gray_count); end
        tick();
    endtask

    task automatic test_wrap();
        bus.req = 2'b01; bus.len0 = 4'd1; bus.dir0 = 1'b1;
        apply_reset();
        tick();
        bus.req = 2'b00;
        n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL wrap_pre: got %b exp 0", bus.wrap); end
        tick();
        n_cmp++; if ({bus.wrap, bus.gray_count} !== 5'b11000) begin n_err++; $display("FAIL wrap_down: got %b exp 11000", {bus.wrap, bus.gray_count}); end
        tick();
        n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL wrap_down_pulse: got %b exp 0", bus.wrap); end
        bus.req = 2'b01; bus.dir0 = 1'b0;
        tick();
        bus.req = 2'b00;
        tick();
        n_cmp++; if ({bus.wrap, bus.gray_count, bus.done} !== 6'b100001) begin n_err++; $display("FAIL wrap_up: got %b exp 100001", {bus.wrap, bus.gray_count, bus.done}); end
        tick();
        n_cmp++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL wrap_up_pulse: got %b exp 0", bus.wrap); end
    endtask

    task automatic test_hold();
        bus.req = 2'b01; bus.len0 = 4'd4; bus.dir0 = 1'b0;
        apply_reset();
        tick();
        bus.req = 2'b10; bus.len0 = 4'd9; bus.dir0 = 1'b1;
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0001) begin n_err++; $display("FAIL hold_step1: got %b exp 0001", bus.gray_count); end
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0011) begin n_err++; $display("FAIL hold_step2: got %b exp 0011", bus.gray_count); end
        bus.hold = 1'b1;
        tick();
        n_cmp++; if ({bus.gnt, bus.gray_count} !== 6'b010011) begin n_err++; $display("FAIL hold_frz1: got %b exp 010011", {bus.gnt, bus.gray_count}); end
        tick();
        n_cmp++; if ({bus.gnt, bus.gray_count, bus.done} !== 7'b0100110) begin n_err++; $display("FAIL hold_frz2: got %b exp 0100110", {bus.gnt, bus.gray_count, bus.done}); end
        bus.hold = 1'b0;
        tick();
        n_cmp++; if ({bus.gray_count, bus.done} !== 5'b00100) begin n_err++; $display("FAIL hold_step3: got %b exp 00100", {bus.gray_count, bus.done}); end
        tick();
        n_cmp++; if ({bus.gray_count, bus.done, bus.done_id} !== 6'b011010) begin n_err++; $display("FAIL hold_done: got %b exp 011010", {bus.gray_count, bus.done, bus.done_id}); end
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_midrun_reset_zero_len();
        bus.req = 2'b01; bus.len0 = 4'd5; bus.dir0 = 1'b0;
        apply_reset();
        tick();
        tick();
        n_cmp++; if (bus.gray_count !== 4'b0001) begin n_err++; $display("FAIL mid_pre: got %b exp 0001", bus.gray_count); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.gnt, bus.busy, bus.done, bus.gray_count} !== 8'd0) begin n_err++; $display("FAIL mid_rst: got %b exp 0", {bus.gnt, bus.busy, bus.done, bus.gray_count}); end
        tick();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got %b exp 0", bus.done); end
        bus.req = 2'b11; bus.len0 = 4'd0; bus.len1 = 4'd3;
        reset = 1'b1;
        tick();
        n_cmp++; if ({bus.gnt, bus.done, bus.done_id, bus.busy, bus.gray_count} !== 9'b011010000) begin n_err++; $display("FAIL zero_len: got %b exp 011010000", {bus.gnt, bus.done, bus.done_id, bus.busy, bus.gray_count}); end
        bus.req = 2'b00;
        tick();
        n_cmp++; if ({bus.gnt, bus.done, bus.gray_count} !== 7'd0) begin n_err++; $display("FAIL zero_len_idle: got %b exp 0", {bus.gnt, bus.done, bus.gray_count}); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_up_run();
        test_arbitration();
        test_wrap();
        test_hold();
        test_midrun_reset_zero_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
